// File: rtl/isl_sync_lock_ctrl.sv
// Sync-lock controller: measures HSYNC period / lines per frame and drives lock, blanking and mode-change.
// Optional digitizer auto-reset on sync loss is built when ISL_AUTORESET_EN is defined.
module isl_sync_lock_ctrl #(
    parameter int STABLE_FRAMES  = 4,
    parameter int HTOL           = 2,
    parameter int VTOL           = 1,
    parameter int NOSYNC_TIMEOUT = 4095,
    parameter int RST_PULSE      = 1024
) (
    input  logic        ISL_PCLK_i,
    input  logic        sys_reset_n,
    input  logic        enable_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        vs_pol_i,
    output logic        lock_o,
    output logic        blank_o,
    output logic        mode_change_o,
    output logic [11:0] htotal_o,
    output logic [10:0] vtotal_o,
    output logic        isl_reset_n_o
);

    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15 || RST_PULSE < 1 ||
        NOSYNC_TIMEOUT < 1 || NOSYNC_TIMEOUT > 4095) begin : g_param_chk
        $error("isl_sync_lock_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_SEARCH, ST_CAPTURE, ST_VERIFY, ST_LOCKED} state_t;
    state_t state_q, state_d;

    logic        hs_r_q, hs_p_q, vs_r_q, vs_p_q;
    logic        hfall, vlead, timeout_raw, timeout, pulse_act, match;
    logic [11:0] hcnt_q, hcnt_d, hmeas_q, hmeas_d, nos_q, nos_d, hdiff;
    logic [11:0] cand_h_q, cand_h_d, ht_q, ht_d;
    logic [10:0] vcnt_q, vcnt_d, vinc, vmeas, vdiff, cand_v_q, cand_v_d, vt_q, vt_d;
    logic [3:0]  stable_q, stable_d;
    logic        lock_q, lock_d, blank_q, blank_d, mc_q, mc_d;

    assign hfall = hs_p_q & ~hs_r_q;
    assign vlead = vs_pol_i ? (vs_r_q & ~vs_p_q) : (~vs_r_q & vs_p_q);

    // A HSYNC edge coincident with the VSYNC edge belongs to the ending frame.
    always_comb begin
        hcnt_d  = hfall ? '0 : (&hcnt_q ? hcnt_q : hcnt_q + 12'd1);
        hmeas_d = hfall ? (&hcnt_q ? hcnt_q : hcnt_q + 12'd1) : hmeas_q;
        vinc    = &vcnt_q ? vcnt_q : vcnt_q + 11'd1;
        vmeas   = hfall ? vinc : vcnt_q;
        vcnt_d  = vcnt_q;
        if (vlead)      vcnt_d = '0;
        else if (hfall) vcnt_d = vinc;
        nos_d   = (hfall || pulse_act) ? '0 : (&nos_q ? nos_q : nos_q + 12'd1);
        hdiff   = (hmeas_d >= cand_h_q) ? hmeas_d - cand_h_q : cand_h_q - hmeas_d;
        vdiff   = (vmeas >= cand_v_q) ? vmeas - cand_v_q : cand_v_q - vmeas;
    end

    assign match       = (hdiff <= 12'(HTOL)) && (vdiff <= 11'(VTOL));
    assign timeout_raw = (nos_q == 12'(NOSYNC_TIMEOUT));
    assign timeout     = timeout_raw && !pulse_act;

    always_comb begin
        state_d  = state_q;
        cand_h_d = cand_h_q;
        cand_v_d = cand_v_q;
        stable_d = stable_q;
        ht_d     = ht_q;
        vt_d     = vt_q;
        mc_d     = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (timeout && state_q != ST_IDLE) begin
            state_d = ST_SEARCH;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_SEARCH;
                ST_SEARCH:  if (vlead) state_d = ST_CAPTURE;
                ST_CAPTURE: if (vlead) begin
                    cand_h_d = hmeas_d;
                    cand_v_d = vmeas;
                    stable_d = '0;
                    state_d  = ST_VERIFY;
                end
                ST_VERIFY:  if (vlead) begin
                    if (!match) begin
                        cand_h_d = hmeas_d;
                        cand_v_d = vmeas;
                        stable_d = '0;
                    end else if (stable_q + 4'd1 == 4'(STABLE_FRAMES)) begin
                        state_d = ST_LOCKED;
                        ht_d    = cand_h_q;
                        vt_d    = cand_v_q;
                        mc_d    = 1'b1;
                    end else begin
                        stable_d = stable_q + 4'd1;
                    end
                end
                ST_LOCKED:  if (vlead && !match) begin
                    cand_h_d = hmeas_d;
                    cand_v_d = vmeas;
                    stable_d = '0;
                    state_d  = ST_VERIFY;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
        lock_d  = (state_d == ST_LOCKED);
        blank_d = ~lock_d;
    end

    // Sync inputs reset to their idle levels so release does not fake an edge.
    always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            hs_r_q   <= 1'b1;
            hs_p_q   <= 1'b1;
            vs_r_q   <= 1'b0;
            vs_p_q   <= 1'b0;
            state_q  <= ST_IDLE;
            hcnt_q   <= '0;
            hmeas_q  <= '0;
            vcnt_q   <= '0;
            nos_q    <= '0;
            cand_h_q <= '0;
            cand_v_q <= '0;
            stable_q <= '0;
            ht_q     <= '0;
            vt_q     <= '0;
            lock_q   <= 1'b0;
            blank_q  <= 1'b1;
            mc_q     <= 1'b0;
        end else begin
            hs_r_q   <= hsync_i;
            hs_p_q   <= hs_r_q;
            vs_r_q   <= vsync_i;
            vs_p_q   <= vs_r_q;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            hmeas_q  <= hmeas_d;
            vcnt_q   <= vcnt_d;
            nos_q    <= nos_d;
            cand_h_q <= cand_h_d;
            cand_v_q <= cand_v_d;
            stable_q <= stable_d;
            ht_q     <= ht_d;
            vt_q     <= vt_d;
            lock_q   <= lock_d;
            blank_q  <= blank_d;
            mc_q     <= mc_d;
        end
    end

`ifdef ISL_AUTORESET_EN
    localparam int RW = $clog2(RST_PULSE + 1);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          pulse_q, pulse_d, pulse_start;

    assign pulse_start = timeout_raw && !pulse_q && (state_q == ST_SEARCH);

    always_comb begin
        pulse_d = pulse_q;
        rcnt_d  = rcnt_q;
        if (pulse_start) begin
            pulse_d = 1'b1;
            rcnt_d  = RW'(RST_PULSE - 1);
        end else if (pulse_q) begin
            if (rcnt_q == '0) pulse_d = 1'b0;
            else              rcnt_d  = rcnt_q - RW'(1);
        end
    end

    always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            pulse_q <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            pulse_q <= pulse_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign pulse_act     = pulse_q;
    assign isl_reset_n_o = ~pulse_q;
`else
    assign pulse_act     = 1'b0;
    assign isl_reset_n_o = 1'b1;
`endif

    assign lock_o        = lock_q;
    assign blank_o       = blank_q;
    assign mode_change_o = mc_q;
    assign htotal_o      = ht_q;
    assign vtotal_o      = vt_q;

endmodule

// File: tb/tb_isl_sync_lock_ctrl.sv
// Bench for isl_sync_lock_ctrl: table of frame segments, hand sequences for latency/timeout/reset/polarity,
// and a randomized frame stream checked against a frame-level lock model.
module tb_isl_sync_lock_ctrl;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, hs = 1'b1, vs = 1'b0, pol = 1'b1;
    logic        lock, blank, mc, isl_rn;
    logic [11:0] ht;
    logic [10:0] vt;

    always #5 clk = ~clk;

    isl_sync_lock_ctrl dut (
        .ISL_PCLK_i(clk), .sys_reset_n(rst_n), .enable_i(en), .hsync_i(hs), .vsync_i(vs),
        .vs_pol_i(pol), .lock_o(lock), .blank_o(blank), .mode_change_o(mc),
        .htotal_o(ht), .vtotal_o(vt), .isl_reset_n_o(isl_rn)
    );

    int nvec = 0, nerr = 0;
    int cyc = 0, mc_cnt = 0, mc_wide = 0, mc_bad = 0, rst_low = 0, last_gap = -1;
    int vs_edge_cyc = 0, last_hs_cyc = 0;
    logic mc_prev = 1'b0, lock_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mc) begin
            mc_cnt <= mc_cnt + 1;
            if (mc_prev) mc_wide <= mc_wide + 1;
        end
        if (lock && !lock_prev) begin
            last_gap <= cyc - vs_edge_cyc;
            if (!mc) mc_bad <= mc_bad + 1;
        end
        if (!isl_rn) rst_low <= rst_low + 1;
        mc_prev   <= mc;
        lock_prev <= lock;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One frame: HSYNC low for 4 pclks at each line start, VSYNC active from line 0 pixel 10
    // to line 1 pixel 10. Each VSYNC edge therefore reports the previous frame's h/v.
    task automatic drive_frame(input int h, input int v);
        for (int l = 0; l < v; l++) begin
            for (int c = 0; c < h; c++) begin
                @(posedge clk); #1;
                hs = (c < 4) ? 1'b0 : 1'b1;
                if (c == 0) last_hs_cyc = cyc;
                if (l == 0 && c == 10) begin vs = pol; vs_edge_cyc = cyc; end
                if (l == 1 && c == 10) vs = ~pol;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // Frame-level reference: arming edge, candidate edge, then run of matches.
    bit m_armed, m_hascand, m_lock;
    int m_ch, m_cv, m_run, m_ht, m_vt, m_pulses;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic m_reset();
        m_armed = 0; m_hascand = 0; m_lock = 0;
        m_ch = 0; m_cv = 0; m_run = 0; m_ht = 0; m_vt = 0; m_pulses = 0;
    endtask

    task automatic m_edge(input int h, input int v);
        if (!m_armed) m_armed = 1;
        else if (!m_hascand) begin m_ch = h; m_cv = v; m_run = 0; m_hascand = 1; end
        else if (iabs(h - m_ch) <= 2 && iabs(v - m_cv) <= 1) begin
            if (!m_lock) begin
                m_run++;
                if (m_run == 4) begin m_lock = 1; m_ht = m_ch; m_vt = m_cv; m_pulses++; end
            end
        end else begin
            m_ch = h; m_cv = v; m_run = 0; m_lock = 0;
        end
    endtask

    typedef struct {
        int h; int v; int frames; bit ilace;
        bit lk; int eht; int evt; int pulses;
    } row_t;
    row_t tbl[9];

    initial begin
        int snap, gap, waited, ph, pv, h, v;
        int hs_set[5] = '{30, 31, 32, 34, 37};
        int vs_set[4] = '{10, 11, 12, 13};

        tbl[0] = '{858, 3, 6, 1'b0, 1'b1, 858, 3, 1};  // first lock
        tbl[1] = '{864, 3, 2, 1'b0, 1'b0, 858, 3, 0};  // line length change drops lock
        tbl[2] = '{864, 3, 4, 1'b0, 1'b1, 864, 3, 1};  // relock after 4 matching frames
        tbl[3] = '{40, 13, 1, 1'b0, 1'b1, 864, 3, 0};  // edge still reports the 864 frame
        tbl[4] = '{40, 13, 5, 1'b0, 1'b1, 40, 13, 1};
        tbl[5] = '{40, 13, 6, 1'b1, 1'b1, 40, 13, 0};  // 13/12 field alternation
        tbl[6] = '{42, 13, 3, 1'b0, 1'b1, 40, 13, 0};  // h off by exactly HTOL
        tbl[7] = '{43, 13, 2, 1'b0, 1'b0, 40, 13, 0};  // h off by HTOL+1
        tbl[8] = '{43, 15, 2, 1'b0, 1'b0, 40, 13, 0};  // v off by VTOL+1

        #3 rst_n = 1'b0;
        #2;
        chk("reset lock", int'(lock), 0);
        chk("reset blank", int'(blank), 1);
        chk("reset mode_change", int'(mc), 0);
        chk("reset htotal", int'(ht), 0);
        chk("reset vtotal", int'(vt), 0);
        chk("reset isl_reset_n", int'(isl_rn), 1);
        idle(3);
        rst_n = 1'b1;
        en = 1'b1;
        idle(3);

        for (int r = 0; r < 9; r++) begin
            snap = mc_cnt;
            for (int f = 0; f < tbl[r].frames; f++)
                drive_frame(tbl[r].h, (tbl[r].ilace && f[0]) ? tbl[r].v - 1 : tbl[r].v);
            chk($sformatf("row%0d lock", r), int'(lock), int'(tbl[r].lk));
            chk($sformatf("row%0d blank", r), int'(blank), int'(!tbl[r].lk));
            chk($sformatf("row%0d htotal", r), int'(ht), tbl[r].eht);
            chk($sformatf("row%0d vtotal", r), int'(vt), tbl[r].evt);
            chk($sformatf("row%0d pulses", r), mc_cnt - snap, tbl[r].pulses);
            if (r == 0) chk("lock latency after 6th vsync edge", last_gap, 2);
        end

        // Lock on 43x15, then stop HSYNC: detect 1 + clear 1 + 4095 count + update 1 pclks.
        for (int f = 0; f < 5; f++) drive_frame(43, 15);
        chk("pre-timeout lock", int'(lock), 1);
        chk("pre-timeout htotal", int'(ht), 43);
        chk("pre-timeout vtotal", int'(vt), 15);
        snap = rst_low;
        waited = 0;
        while (lock && waited < 5000) begin @(posedge clk); #1; waited++; end
        chk("nosync lock drop", int'(lock), 0);
        gap = cyc - last_hs_cyc;
        chk("nosync delay 4096..4100", int'(gap >= 4096 && gap <= 4100), 1);
        chk("nosync blank", int'(blank), 1);
        chk("nosync htotal held", int'(ht), 43);
        idle(1100);
`ifdef ISL_AUTORESET_EN
        chk("autoreset pulse width", rst_low - snap, 1024);
`else
        chk("isl_reset_n stays high", rst_low - snap, 0);
`endif

        // Reset in VERIFY: a fresh arm/capture/verify run is needed afterwards.
        for (int f = 0; f < 3; f++) drive_frame(40, 13);
        chk("verify before reset lock", int'(lock), 0);
        rst_n = 1'b0;
        #1;
        chk("mid reset lock", int'(lock), 0);
        chk("mid reset blank", int'(blank), 1);
        chk("mid reset htotal", int'(ht), 0);
        chk("mid reset vtotal", int'(vt), 0);
        chk("mid reset mode_change", int'(mc), 0);
        idle(2);
        rst_n = 1'b1;
        snap = mc_cnt;
        for (int f = 0; f < 5; f++) drive_frame(40, 13);
        chk("post reset 5 frames lock", int'(lock), 0);
        drive_frame(40, 13);
        chk("post reset 6 frames lock", int'(lock), 1);
        chk("post reset htotal", int'(ht), 40);
        chk("post reset pulses", mc_cnt - snap, 1);

        // Negative-polarity VSYNC must lock exactly like the positive case.
        rst_n = 1'b0; pol = 1'b0; vs = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        for (int f = 0; f < 5; f++) drive_frame(40, 13);
        chk("negpol 5 frames lock", int'(lock), 0);
        drive_frame(40, 13);
        chk("negpol lock", int'(lock), 1);
        chk("negpol latency", last_gap, 2);
        chk("negpol htotal", int'(ht), 40);
        chk("negpol vtotal", int'(vt), 13);
        en = 1'b0;
        @(posedge clk); #1;
        chk("disable lock", int'(lock), 0);
        chk("disable blank", int'(blank), 1);
        chk("disable htotal held", int'(ht), 40);

        // Random frame stream against the frame-level model.
        rst_n = 1'b0; pol = 1'($urandom_range(0, 1)); vs = ~pol; en = 1'b1;
        idle(2);
        rst_n = 1'b1;
        m_reset();
        snap = mc_cnt;
        ph = 0; pv = 0;
        h = hs_set[0]; v = vs_set[2];
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                h = hs_set[$urandom_range(0, 4)];
                v = vs_set[$urandom_range(0, 3)];
            end
            drive_frame(h, v);
            m_edge(ph, pv);
            ph = h; pv = v;
            chk($sformatf("rand%0d lock", i), int'(lock), int'(m_lock));
            chk($sformatf("rand%0d htotal", i), int'(ht), m_ht);
            chk($sformatf("rand%0d vtotal", i), int'(vt), m_vt);
        end
        chk("rand pulses", mc_cnt - snap, m_pulses);
        chk("mode_change single-cycle", mc_wide, 0);
        chk("mode_change with lock rise", mc_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
